gnn_infer_core: RTL and testbench



---
 rtl/gnn_pkg.sv | 29 ++
 rtl/gnn_if.sv | 50 +++++
 rtl/gnn_dot4.sv | 23 ++
 rtl/gnn_infer_core.sv | 130 +++++++++++++
 tb/tb_gnn_infer_core.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/gnn_pkg.sv
// Shared widths, word types and ring topology for the GNN inference datapath.
package gnn_pkg;

  localparam int unsigned FEAT_W = 5;
  localparam int unsigned WGT_W  = FEAT_W;
  localparam int unsigned HID_W  = 12;
  localparam int unsigned AGG_W  = 14;
  localparam int unsigned OUT_W  = 21;

  localparam int unsigned NODES = 4;
  localparam int unsigned FEATS = 4;
  localparam int unsigned HIDS  = 4;
  localparam int unsigned OUTS  = 2;

  typedef logic signed [FEAT_W-1:0] feat_t;
  typedef logic signed [WGT_W-1:0]  wgt_t;
  typedef logic signed [HID_W-1:0]  hid_t;
  typedef logic signed [AGG_W-1:0]  agg_t;
  typedef logic signed [OUT_W-1:0]  out_t;

  // Ring neighbours: node n is adjacent to n-1 and n+1 (mod 4).
  localparam logic [1:0] RING_PREV [NODES] = '{2'd3, 2'd0, 2'd1, 2'd2};
  localparam logic [1:0] RING_NEXT [NODES] = '{2'd1, 2'd2, 2'd3, 2'd0};

  function automatic hid_t relu(input hid_t z);
    return z[HID_W-1] ? '0 : z;
  endfunction

endpackage

// File: rtl/gnn_if.sv
// Flat feature/weight/result bundle of the GNN core, grouped as one interface.
interface gnn_if;
  import gnn_pkg::*;

  logic  in_ready;
  feat_t x0_node0, x1_node0, x2_node0, x3_node0;
  feat_t x0_node1, x1_node1, x2_node1, x3_node1;
  feat_t x0_node2, x1_node2, x2_node2, x3_node2;
  feat_t x0_node3, x1_node3, x2_node3, x3_node3;
  wgt_t  w04, w05, w06, w07;
  wgt_t  w14, w15, w16, w17;
  wgt_t  w24, w25, w26, w27;
  wgt_t  w34, w35, w36, w37;
  wgt_t  w48, w49, w58, w59, w68, w69, w78, w79;
  out_t  out0_node0, out1_node0, out0_node1, out1_node1;
  out_t  out0_node2, out1_node2, out0_node3, out1_node3;
  logic  out0_ready_node0, out1_ready_node0, out0_ready_node1, out1_ready_node1;
  logic  out0_ready_node2, out1_ready_node2, out0_ready_node3, out1_ready_node3;

  modport master (
    output in_ready,
    output x0_node0, x1_node0, x2_node0, x3_node0,
    output x0_node1, x1_node1, x2_node1, x3_node1,
    output x0_node2, x1_node2, x2_node2, x3_node2,
    output x0_node3, x1_node3, x2_node3, x3_node3,
    output w04, w05, w06, w07, w14, w15, w16, w17,
    output w24, w25, w26, w27, w34, w35, w36, w37,
    output w48, w49, w58, w59, w68, w69, w78, w79,
    input  out0_node0, out1_node0, out0_node1, out1_node1,
    input  out0_node2, out1_node2, out0_node3, out1_node3,
    input  out0_ready_node0, out1_ready_node0, out0_ready_node1, out1_ready_node1,
    input  out0_ready_node2, out1_ready_node2, out0_ready_node3, out1_ready_node3
  );

  modport slave (
    input  in_ready,
    input  x0_node0, x1_node0, x2_node0, x3_node0,
    input  x0_node1, x1_node1, x2_node1, x3_node1,
    input  x0_node2, x1_node2, x2_node2, x3_node2,
    input  x0_node3, x1_node3, x2_node3, x3_node3,
    input  w04, w05, w06, w07, w14, w15, w16, w17,
    input  w24, w25, w26, w27, w34, w35, w36, w37,
    input  w48, w49, w58, w59, w68, w69, w78, w79,
    output out0_node0, out1_node0, out0_node1, out1_node1,
    output out0_node2, out1_node2, out0_node3, out1_node3,
    output out0_ready_node0, out1_ready_node0, out0_ready_node1, out1_ready_node1,
    output out0_ready_node2, out1_ready_node2, out0_ready_node3, out1_ready_node3
  );

endinterface

// File: rtl/gnn_dot4.sv
// Signed 4-term dot product; operands are sign-extended to the result width.
module gnn_dot4 #(
  parameter int unsigned IN_W  = 5,
  parameter int unsigned WT_W  = 5,
  parameter int unsigned RES_W = 12
) (
  input  logic signed [IN_W-1:0]  a [4],
  input  logic signed [WT_W-1:0]  w [4],
  output logic signed [RES_W-1:0] y
);

  logic signed [RES_W-1:0] acc;

  // Accumulate the four products at full result width.
  always_comb begin
    acc = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      acc = acc + (RES_W'(a[i]) * RES_W'(w[i]));
    end
    y = acc;
  end

endmodule

// File: rtl/gnn_infer_core.sv
// Two-layer GNN inference on a 4-node ring: dense+ReLU, ring aggregate, dense.
module gnn_infer_core
  import gnn_pkg::*;
(
  input logic  clk,
  input logic  rst_n,
  gnn_if.slave bus
);

  feat_t x      [NODES][FEATS];
  wgt_t  w1_col [HIDS][FEATS];
  wgt_t  w2_col [OUTS][HIDS];
  hid_t  z1     [NODES][HIDS];
  hid_t  h_q    [NODES][HIDS];
  wgt_t  w2_s1  [OUTS][HIDS];
  wgt_t  w2_s2  [OUTS][HIDS];
  agg_t  agg_d  [NODES][HIDS];
  agg_t  agg_q  [NODES][HIDS];
  out_t  y2     [NODES][OUTS];
  out_t  out_q  [NODES][OUTS];
  logic  v1, v2, v3;

  assign x[0] = '{bus.x0_node0, bus.x1_node0, bus.x2_node0, bus.x3_node0};
  assign x[1] = '{bus.x0_node1, bus.x1_node1, bus.x2_node1, bus.x3_node1};
  assign x[2] = '{bus.x0_node2, bus.x1_node2, bus.x2_node2, bus.x3_node2};
  assign x[3] = '{bus.x0_node3, bus.x1_node3, bus.x2_node3, bus.x3_node3};

  assign w1_col[0] = '{bus.w04, bus.w14, bus.w24, bus.w34};
  assign w1_col[1] = '{bus.w05, bus.w15, bus.w25, bus.w35};
  assign w1_col[2] = '{bus.w06, bus.w16, bus.w26, bus.w36};
  assign w1_col[3] = '{bus.w07, bus.w17, bus.w27, bus.w37};

  assign w2_col[0] = '{bus.w48, bus.w58, bus.w68, bus.w78};
  assign w2_col[1] = '{bus.w49, bus.w59, bus.w69, bus.w79};

  for (genvar n = 0; n < NODES; n++) begin : g_l1_node
    for (genvar h = 0; h < HIDS; h++) begin : g_l1_hid
      gnn_dot4 #(.IN_W(FEAT_W), .WT_W(WGT_W), .RES_W(HID_W)) u_dot (
        .a(x[n]),
        .w(w1_col[h]),
        .y(z1[n][h])
      );
    end
  end

  // S1: ReLU'd hidden values; layer-2 weights travel with the sample so a
  // result always uses the weights presented alongside its features.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      for (int unsigned n = 0; n < NODES; n++)
        for (int unsigned h = 0; h < HIDS; h++) h_q[n][h] <= '0;
      for (int unsigned o = 0; o < OUTS; o++)
        for (int unsigned h = 0; h < HIDS; h++) w2_s1[o][h] <= '0;
    end else begin
      v1 <= bus.in_ready;
      if (bus.in_ready) begin
        for (int unsigned n = 0; n < NODES; n++)
          for (int unsigned h = 0; h < HIDS; h++) h_q[n][h] <= relu(z1[n][h]);
        w2_s1 <= w2_col;
      end
    end
  end

  // Self plus both ring neighbours, widened before summing.
  always_comb begin
    for (int unsigned n = 0; n < NODES; n++)
      for (int unsigned h = 0; h < HIDS; h++)
        agg_d[n][h] = AGG_W'(h_q[n][h]) + AGG_W'(h_q[RING_PREV[n]][h])
                    + AGG_W'(h_q[RING_NEXT[n]][h]);
  end

  // S2: aggregates and the matching layer-2 weights.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2 <= 1'b0;
      for (int unsigned n = 0; n < NODES; n++)
        for (int unsigned h = 0; h < HIDS; h++) agg_q[n][h] <= '0;
      for (int unsigned o = 0; o < OUTS; o++)
        for (int unsigned h = 0; h < HIDS; h++) w2_s2[o][h] <= '0;
    end else begin
      v2 <= v1;
      if (v1) begin
        agg_q <= agg_d;
        w2_s2 <= w2_s1;
      end
    end
  end

  for (genvar n = 0; n < NODES; n++) begin : g_l2_node
    for (genvar o = 0; o < OUTS; o++) begin : g_l2_out
      gnn_dot4 #(.IN_W(AGG_W), .WT_W(WGT_W), .RES_W(OUT_W)) u_dot (
        .a(agg_q[n]),
        .w(w2_s2[o]),
        .y(y2[n][o])
      );
    end
  end

  // S3: output registers and ready flag; outputs hold while no valid arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3 <= 1'b0;
      for (int unsigned n = 0; n < NODES; n++)
        for (int unsigned o = 0; o < OUTS; o++) out_q[n][o] <= '0;
    end else begin
      v3 <= v2;
      if (v2) out_q <= y2;
    end
  end

  assign bus.out0_node0 = out_q[0][0];
  assign bus.out1_node0 = out_q[0][1];
  assign bus.out0_node1 = out_q[1][0];
  assign bus.out1_node1 = out_q[1][1];
  assign bus.out0_node2 = out_q[2][0];
  assign bus.out1_node2 = out_q[2][1];
  assign bus.out0_node3 = out_q[3][0];
  assign bus.out1_node3 = out_q[3][1];

  assign bus.out0_ready_node0 = v3;
  assign bus.out1_ready_node0 = v3;
  assign bus.out0_ready_node1 = v3;
  assign bus.out1_ready_node1 = v3;
  assign bus.out0_ready_node2 = v3;
  assign bus.out1_ready_node2 = v3;
  assign bus.out0_ready_node3 = v3;
  assign bus.out1_ready_node3 = v3;

endmodule

// File: tb/tb_gnn_infer_core.sv
// Directed self-checking bench for gnn_infer_core.
module tb_gnn_infer_core;
  import gnn_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  gnn_if bus ();

  gnn_infer_core dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  feat_t xv  [4][4];  // [node][feature]
  wgt_t  w1v [4][4];  // [feature][hidden-4]
  wgt_t  w2v [4][2];  // [hidden-4][output-8]

  out_t obs [4][2];
  logic rdy [4][2];
  assign obs[0][0] = bus.out0_node0;
  assign obs[0][1] = bus.out1_node0;
  assign obs[1][0] = bus.out0_node1;
  assign obs[1][1] = bus.out1_node1;
  assign obs[2][0] = bus.out0_node2;
  assign obs[2][1] = bus.out1_node2;
  assign obs[3][0] = bus.out0_node3;
  assign obs[3][1] = bus.out1_node3;
  assign rdy[0][0] = bus.out0_ready_node0;
  assign rdy[0][1] = bus.out1_ready_node0;
  assign rdy[1][0] = bus.out0_ready_node1;
  assign rdy[1][1] = bus.out1_ready_node1;
  assign rdy[2][0] = bus.out0_ready_node2;
  assign rdy[2][1] = bus.out1_ready_node2;
  assign rdy[3][0] = bus.out0_ready_node3;
  assign rdy[3][1] = bus.out1_ready_node3;

  task automatic drive();
    bus.x0_node0 = xv[0][0]; bus.x1_node0 = xv[0][1]; bus.x2_node0 = xv[0][2]; bus.x3_node0 = xv[0][3];
    bus.x0_node1 = xv[1][0]; bus.x1_node1 = xv[1][1]; bus.x2_node1 = xv[1][2]; bus.x3_node1 = xv[1][3];
    bus.x0_node2 = xv[2][0]; bus.x1_node2 = xv[2][1]; bus.x2_node2 = xv[2][2]; bus.x3_node2 = xv[2][3];
    bus.x0_node3 = xv[3][0]; bus.x1_node3 = xv[3][1]; bus.x2_node3 = xv[3][2]; bus.x3_node3 = xv[3][3];
    bus.w04 = w1v[0][0]; bus.w05 = w1v[0][1]; bus.w06 = w1v[0][2]; bus.w07 = w1v[0][3];
    bus.w14 = w1v[1][0]; bus.w15 = w1v[1][1]; bus.w16 = w1v[1][2]; bus.w17 = w1v[1][3];
    bus.w24 = w1v[2][0]; bus.w25 = w1v[2][1]; bus.w26 = w1v[2][2]; bus.w27 = w1v[2][3];
    bus.w34 = w1v[3][0]; bus.w35 = w1v[3][1]; bus.w36 = w1v[3][2]; bus.w37 = w1v[3][3];
    bus.w48 = w2v[0][0]; bus.w49 = w2v[0][1]; bus.w58 = w2v[1][0]; bus.w59 = w2v[1][1];
    bus.w68 = w2v[2][0]; bus.w69 = w2v[2][1]; bus.w78 = w2v[3][0]; bus.w79 = w2v[3][1];
  endtask

  task automatic set_all(input feat_t xval, input wgt_t w1val, input wgt_t w2val);
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        xv[i][j]  = xval;
        w1v[i][j] = w1val;
      end
      for (int j = 0; j < 2; j++) w2v[i][j] = w2val;
    end
  endtask

  task automatic set_ring();
    set_all(5'sd0, 5'sd0, 5'sd0);
    xv[0][0]  = 5'sd1;
    w1v[0][0] = 5'sd1;
    w2v[0][0] = 5'sd2;
    w2v[0][1] = -5'sd3;
  endtask

  task automatic idle(input int cycles);
    @(negedge clk);
    bus.in_ready = 1'b0;
    repeat (cycles) @(posedge clk);
  endtask

  // Present the current vectors for one sampled cycle; returns just after
  // the edge on which its results land.
  task automatic run_single();
    @(negedge clk);
    drive();
    bus.in_ready = 1'b1;
    @(negedge clk);
    bus.in_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int n = 0; n < 4; n++)
      for (int f = 0; f < 4; f++) begin
        xv[n][f]  = 5'($urandom);
        w1v[n][f] = 5'($urandom);
      end
    for (int h = 0; h < 4; h++)
      for (int o = 0; o < 2; o++) w2v[h][o] = 5'($urandom);
    drive();
    bus.in_ready = 1'b1;
    rst_n = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    for (int n = 0; n < 4; n++)
      for (int o = 0; o < 2; o++) begin
        checks++;
        if (obs[n][o] !== 21'sd0) begin
          errors++;
          $display("FAIL reset out%0d_node%0d got %0d expected 0", o, n, obs[n][o]);
        end
        checks++;
        if (rdy[n][o] !== 1'b0) begin
          errors++;
          $display("FAIL reset ready%0d_node%0d got %b expected 0", o, n, rdy[n][o]);
        end
      end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (rdy[0][0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_early_ready got %b expected 0", rdy[0][0]);
    end
    @(posedge clk);
    #1;
    for (int n = 0; n < 4; n++)
      for (int o = 0; o < 2; o++) begin
        checks++;
        if (rdy[n][o] !== 1'b1) begin
          errors++;
          $display("FAIL reset_first_ready%0d_node%0d got %b expected 1", o, n, rdy[n][o]);
        end
      end
    idle(4);
  endtask

  task automatic test_uniform(input string name, input feat_t xval, input wgt_t w1val,
                              input wgt_t w2val, input out_t expv);
    set_all(xval, w1val, w2val);
    run_single();
    for (int n = 0; n < 4; n++)
      for (int o = 0; o < 2; o++) begin
        checks++;
        if (obs[n][o] !== expv) begin
          errors++;
          $display("FAIL %s out%0d_node%0d got %0d expected %0d", name, o, n, obs[n][o], expv);
        end
        checks++;
        if (rdy[n][o] !== 1'b1) begin
          errors++;
          $display("FAIL %s ready%0d_node%0d got %b expected 1", name, o, n, rdy[n][o]);
        end
      end
    idle(4);
  endtask

  task automatic test_ring();
    out_t e0, e1;
    set_ring();
    run_single();
    for (int n = 0; n < 4; n++) begin
      e0 = (n == 2) ? 21'sd0 : 21'sd2;
      e1 = (n == 2) ? 21'sd0 : -21'sd3;
      checks++;
      if (obs[n][0] !== e0) begin
        errors++;
        $display("FAIL ring out0_node%0d got %0d expected %0d", n, obs[n][0], e0);
      end
      checks++;
      if (obs[n][1] !== e1) begin
        errors++;
        $display("FAIL ring out1_node%0d got %0d expected %0d", n, obs[n][1], e1);
      end
    end
    idle(4);
  endtask

  task automatic test_back_to_back();
    out_t e0, e1;
    @(negedge clk);
    set_ring();
    drive();
    bus.in_ready = 1'b1;
    @(negedge clk);
    set_all(5'sd15, 5'sd15, 5'sd15);
    drive();
    @(negedge clk);
    bus.in_ready = 1'b0;
    set_all(-5'sd16, -5'sd16, -5'sd16);
    drive();
    @(posedge clk);
    #1;
    for (int n = 0; n < 4; n++) begin
      e0 = (n == 2) ? 21'sd0 : 21'sd2;
      e1 = (n == 2) ? 21'sd0 : -21'sd3;
      checks++;
      if (obs[n][0] !== e0 || obs[n][1] !== e1 || rdy[n][0] !== 1'b1) begin
        errors++;
        $display("FAIL stream_A node%0d got %0d/%0d rdy %b expected %0d/%0d rdy 1",
                 n, obs[n][0], obs[n][1], rdy[n][0], e0, e1);
      end
    end
    @(posedge clk);
    #1;
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (obs[n][0] !== 21'sd162000 || obs[n][1] !== 21'sd162000 || rdy[n][1] !== 1'b1) begin
        errors++;
        $display("FAIL stream_B node%0d got %0d/%0d rdy %b expected 162000/162000 rdy 1",
                 n, obs[n][0], obs[n][1], rdy[n][1]);
      end
    end
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      for (int n = 0; n < 4; n++) begin
        checks++;
        if (obs[n][0] !== 21'sd162000 || obs[n][1] !== 21'sd162000 || rdy[n][0] !== 1'b0) begin
          errors++;
          $display("FAIL stream_hold%0d node%0d got %0d/%0d rdy %b expected 162000/162000 rdy 0",
                   k, n, obs[n][0], obs[n][1], rdy[n][0]);
        end
      end
    end
    idle(2);
  endtask

  task automatic test_reset_midflight();
    set_all(-5'sd16, -5'sd16, -5'sd16);
    @(negedge clk);
    drive();
    bus.in_ready = 1'b1;
    @(negedge clk);
    bus.in_ready = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (obs[n][0] !== 21'sd0 || obs[n][1] !== 21'sd0 || rdy[n][0] !== 1'b0) begin
        errors++;
        $display("FAIL midreset_clear node%0d got %0d/%0d rdy %b expected 0/0 rdy 0",
                 n, obs[n][0], obs[n][1], rdy[n][0]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (rdy[0][0] !== 1'b0 || obs[0][0] !== 21'sd0) begin
        errors++;
        $display("FAIL midreset_discard cycle%0d got rdy %b out %0d expected rdy 0 out 0",
                 k, rdy[0][0], obs[0][0]);
      end
    end
  endtask

  initial begin
    bus.in_ready = 1'b0;
    test_reset();
    test_uniform("max", 5'sd15, 5'sd15, 5'sd15, 21'sd162000);
    test_uniform("min", -5'sd16, -5'sd16, -5'sd16, -21'sd196608);
    test_uniform("relu", 5'sd1, -5'sd1, 5'sd5, 21'sd0);
    test_ring();
    test_back_to_back();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
